// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared widths, constants and FSM encodings for the multiplier path.
// Revision : 1.0
// ============================================================================
package mult_pkg;

    localparam int ACC_W = 64;

    localparam logic [ACC_W-1:0] ACC_SAT = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_adder_64b.sv
`default_nettype none
// ============================================================================
// Module   : sat_adder_64b
// Purpose  : 65-bit unsigned add with wrap or saturate result selection.
// Revision : 1.0
// ============================================================================
module sat_adder_64b
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             sat_en,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign carry  = w_full[ACC_W];
    assign sum    = (sat_en && carry) ? ACC_SAT : w_full[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mac_accumulator_64b.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator_64b
// Purpose  : Accumulates a run of 64-bit products with wrap/saturate and ovf.
// Revision : 1.0
// ============================================================================
module mac_accumulator_64b
    import mult_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sat_en,
    input  logic             prod_valid,
    input  logic [ACC_W-1:0] prod,
    output logic             prod_ready,
    output logic             acc_valid,
    output logic [ACC_W-1:0] acc,
    input  logic             acc_ready,
    output logic             ovf,
    output logic             busy
);

    mac_state_t       r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_sat;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;

    sat_adder_64b u_adder (
        .a      (acc),
        .b      (prod),
        .sat_en (r_sat),
        .sum    (w_sum),
        .carry  (w_carry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_sat   <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        r_cnt <= '0;
                        if (len != '0) begin
                            r_len   <= len;
                            r_sat   <= sat_en;
                            r_state <= ACCUM;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc   <= w_sum;
                        ovf   <= ovf | w_carry;
                        r_cnt <= r_cnt + 1'b1;
                        // Compare before increment so cnt never has to reach 2^LEN_W.
                        if (r_cnt == r_len - 1'b1) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign prod_ready = (r_state == ACCUM);
    assign acc_valid  = (r_state == HOLD);
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
